multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle main controller for the MIPS datapath: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back cycles. It drives every datapath strobe and mux select, resolves BEQ/BNE against the ALU Zero flag, and optionally stalls on a memory ready handshake. It replaces the single-cycle opcode decoder and sits between the instruction register and the shared ALU, register file and memory.

## Interface
- MEM_HANDSHAKE, 1: 1 means memory states wait for MemReady; 0 means memory always completes in one cycle and MemReady is ignored.
- ILLEGAL_TRAP, 1: 1 means an unknown opcode enters TRAP; 0 means an unknown opcode is a NOP and returns to FETCH.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- OpCode  in  6  IR[31:26]; valid from the cycle after IRWrite.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completion for the current access.
- PCWrite  out  1  PC load enable, including the resolved branch condition.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead / MemWrite  out  1 each  memory strobes.
- IRWrite  out  1  instruction register load.
- RegDest  out  1  write register select: 1 = rd, 0 = rt.
- MemtoReg  out  1  write-back select: 1 = MDR, 0 = ALUOut.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = R-type funct, 11 = immediate logic (ALU control selects AND/OR from OpCode[0]).
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- InstrDone  out  1  one-cycle pulse in the last cycle of each instruction.
- Exception  out  1  high while in TRAP.
- State  out  4  current state, for debug.

## Operation
- States and encoding: IDLE=13, FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11, TRAP=12.
- Output default is 0 in every state; only the listed signals are asserted.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite assert only in the completing cycle, i.e. MemReady=1 or MEM_HANDSHAKE=0.
  - Stays in FETCH until completion, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). OpCode is latched into an internal register here; all later states use the latched copy.
- Dispatch from DECODE:
  - LW 100011 or SW 101011 → MEMADR.
  - R-type 000000 → EXEC.
  - BEQ 000100 or BNE 000101 → BRANCH.
  - ADDI 001000, ANDI 001100 or ORI 001101 → IEXEC.
  - J 000010 → JUMP.
  - Any other opcode → TRAP, or FETCH if ILLEGAL_TRAP=0 (InstrDone pulses in DECODE in that case).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is MEMRD for LW, MEMWR for SW.
- MEMRD: MemRead=1, IorD=1. Waits for completion, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDest=0, InstrDone=1. Next state is FETCH.
- MEMWR: MemWrite=1, IorD=1. Waits for completion; InstrDone pulses in the completing cycle. Next state is FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state is RWB.
- RWB: RegWrite=1, RegDest=1, MemtoReg=0, InstrDone=1. Next state is FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10. ALUOp=00 for ADDI, 11 for ANDI/ORI. Next state is IWB.
- IWB: RegWrite=1, RegDest=0, MemtoReg=0, InstrDone=1. Next state is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, InstrDone=1.
  - PCWrite = Zero for BEQ, ~Zero for BNE; this is the only Mealy output.
  - Next state is FETCH.
- JUMP: PCWrite=1, PCSource=10, InstrDone=1. Next state is FETCH.
- TRAP: Exception=1, all strobes 0. Held until reset.

## Timing
- Reset: rst_n sampled low at a clock edge forces State=IDLE and the latched opcode to 000000.
  - All outputs are 0 while in IDLE.
  - The first FETCH is one cycle after the first edge that samples rst_n high.
- Reset mid-instruction or mid-wait: the instruction is abandoned, with no further strobes after the reset edge.
- Zero-wait latency in cycles (FETCH through last state):
  - BEQ/BNE and J: 3.
  - R-type, immediate and SW: 4.
  - LW: 5.
  - Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- While waiting: MemRead/MemWrite and IorD stay steady, and IRWrite, PCWrite and InstrDone are suppressed.
- Only one write strobe (PCWrite, RegWrite or MemWrite) completes per instruction, apart from FETCH's PC+4.

## Structure
- Package mips_ctrl_pkg holds:
  - opcode constants;
  - state encoding (4-bit enum);
  - ALUOp, ALUSrcB and PCSource encodings.
- Sub-module ctrl_out_decode is combinational: state, latched opcode, Zero and memory-done in; all strobes out.
- The top level holds the state register, the opcode latch and next-state logic.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with MemReady=1 → State=13, all outputs 0. After release: IDLE, then FETCH with MemRead=1 and IRWrite=1.
- Instruction latencies with MemReady=1: R-type 000000 → RWB with RegWrite=1 and RegDest=1 on cycle 4; LW → MEMWB with MemtoReg=1 on cycle 5; SW → MemWrite=1 and InstrDone on cycle 4.
- Branches: BEQ with Zero=1 → PCWrite=1 and PCSource=01 in BRANCH; BEQ with Zero=0 → PCWrite=0; BNE gives the opposite result for each Zero value.
- Memory stall: LW with MemReady=0 for 2 cycles in FETCH and 3 cycles in MEMRD → total 10 cycles. IRWrite pulses exactly once, and MemRead holds steady through the waits.
- Illegal opcode 111111: ILLEGAL_TRAP=1 → State=12 and Exception=1 until reset. ILLEGAL_TRAP=0 → InstrDone in DECODE, then FETCH.
- Mid-LW reset: assert rst_n=0 in MEMRD → IDLE next cycle, no RegWrite, latched opcode is 000000.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, state codes,
// datapath select encodings and the bundled strobe struct.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB   = 4'd7,
    S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP  = 4'd11,
    S_TRAP   = 4'd12, S_IDLE   = 4'd13
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGI  = 2'b11;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dest;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       exception;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ANDI, OP_ORI, OP_J: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational strobe decode: Moore outputs per state, plus the branch
// condition and memory-completion gating of the commit strobes.
module ctrl_out_decode
  import mips_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  state_e     state_i,
  input  logic [5:0] op_i,
  input  logic       zero_i,
  input  logic       mem_done_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.ir_write  = mem_done_i;
        ctrl_o.pc_write  = mem_done_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b  = SRCB_IMMSH;
        ctrl_o.instr_done = !ILLEGAL_TRAP && !op_legal(op_i);
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = mem_done_i;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dest   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        // BNE shares the subtract; only the sense of Zero flips
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_op     = ALU_SUB;
        ctrl_o.pc_source  = PCS_ALUOUT;
        ctrl_o.instr_done = 1'b1;
        ctrl_o.pc_write   = (op_i == OP_BNE) ? !zero_i : zero_i;
      end
      S_IEXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = (op_i == OP_ADDI) ? ALU_ADD : ALU_LOGI;
      end
      S_IWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCS_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      S_TRAP:  ctrl_o.exception = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: state register, opcode latch and
// next-state sequencing; strobes come from ctrl_out_decode.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ILLEGAL_TRAP  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OpCode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDest,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       InstrDone,
  output logic       Exception,
  output logic [3:0] State
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d, op_eff;
  logic       mem_done;
  ctrl_t      ctrl;

  assign mem_done = !MEM_HANDSHAKE || MemReady;
  // DECODE sees the live IR field; the latch only becomes valid afterwards
  assign op_eff   = (state_q == S_DECODE) ? OpCode : op_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_done) state_d = S_DECODE;
      S_DECODE: begin
        op_d = OpCode;
        case (OpCode)
          OP_LW, OP_SW:             state_d = S_MEMADR;
          OP_RTYPE:                 state_d = S_EXEC;
          OP_BEQ, OP_BNE:           state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
          OP_J:                     state_d = S_JUMP;
          default: begin
            if (ILLEGAL_TRAP) state_d = S_TRAP;
            else              state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        if (op_q == OP_SW) state_d = S_MEMWR;
        else               state_d = S_MEMRD;
      end
      S_MEMRD:  if (mem_done) state_d = S_MEMWB;
      S_MEMWR:  if (mem_done) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  ctrl_out_decode #(.ILLEGAL_TRAP(ILLEGAL_TRAP)) u_dec (
    .state_i    (state_q),
    .op_i       (op_eff),
    .zero_i     (Zero),
    .mem_done_i (mem_done),
    .ctrl_o     (ctrl)
  );

  assign PCWrite   = ctrl.pc_write;
  assign IorD      = ctrl.iord;
  assign MemRead   = ctrl.mem_read;
  assign MemWrite  = ctrl.mem_write;
  assign IRWrite   = ctrl.ir_write;
  assign RegDest   = ctrl.reg_dest;
  assign MemtoReg  = ctrl.mem_to_reg;
  assign RegWrite  = ctrl.reg_write;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign PCSource  = ctrl.pc_source;
  assign InstrDone = ctrl.instr_done;
  assign Exception = ctrl.exception;
  assign State     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: the driver queues one expected output frame per cycle,
// the negedge monitor pops and compares against dut_a (trap) or dut_b (nop).
module tb_multicycle_control;

  typedef struct packed {
    logic       pcw, iord, mr, mw, irw, rd, m2r, rw, a;
    logic [1:0] b, op, pcs;
    logic       done, exc;
  } o_t;

  typedef struct {
    string      nm;
    logic       sel;
    logic [3:0] st;
    o_t         o;
  } frame_t;

  localparam logic [3:0] F = 0, D = 1, MADR = 2, MRD = 3, MWB = 4, MWR = 5,
                         EX = 6, RWB = 7, BR = 8, IEX = 9, IWB = 10, JMP = 11,
                         TRP = 12, IDLE = 13;
  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                         ORI = 6'b001101, J = 6'b000010, BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] OpCode;
  logic       Zero, MemReady;

  logic       pcw_a, iord_a, mr_a, mw_a, irw_a, rd_a, m2r_a, rw_a, a_a, done_a, exc_a;
  logic [1:0] b_a, op_a, pcs_a;
  logic [3:0] st_a;
  logic       pcw_b, iord_b, mr_b, mw_b, irw_b, rd_b, m2r_b, rw_b, a_b, done_b, exc_b;
  logic [1:0] b_b, op_b, pcs_b;
  logic [3:0] st_b;

  int total = 0;
  int bad   = 0;
  frame_t sbq[$];

  always #5 clk = ~clk;

  multicycle_control #(.MEM_HANDSHAKE(1'b1), .ILLEGAL_TRAP(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(pcw_a), .IorD(iord_a), .MemRead(mr_a), .MemWrite(mw_a), .IRWrite(irw_a),
    .RegDest(rd_a), .MemtoReg(m2r_a), .RegWrite(rw_a), .ALUSrcA(a_a), .ALUSrcB(b_a),
    .ALUOp(op_a), .PCSource(pcs_a), .InstrDone(done_a), .Exception(exc_a), .State(st_a)
  );

  multicycle_control #(.MEM_HANDSHAKE(1'b1), .ILLEGAL_TRAP(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(pcw_b), .IorD(iord_b), .MemRead(mr_b), .MemWrite(mw_b), .IRWrite(irw_b),
    .RegDest(rd_b), .MemtoReg(m2r_b), .RegWrite(rw_b), .ALUSrcA(a_b), .ALUSrcB(b_b),
    .ALUOp(op_b), .PCSource(pcs_b), .InstrDone(done_b), .Exception(exc_b), .State(st_b)
  );

  o_t oa, ob;
  assign oa = {pcw_a, iord_a, mr_a, mw_a, irw_a, rd_a, m2r_a, rw_a, a_a, b_a, op_a, pcs_a, done_a, exc_a};
  assign ob = {pcw_b, iord_b, mr_b, mw_b, irw_b, rd_b, m2r_b, rw_b, a_b, b_b, op_b, pcs_b, done_b, exc_b};

  // Moore strobes per state, written from the state table; commit bits added per step
  function automatic o_t tbl(input logic [3:0] st, input logic [5:0] op);
    o_t o = '0;
    case (st)
      F:    begin o.mr = 1; o.b = 2'b01; end
      D:    o.b = 2'b11;
      MADR: begin o.a = 1; o.b = 2'b10; end
      MRD:  begin o.mr = 1; o.iord = 1; end
      MWB:  begin o.rw = 1; o.m2r = 1; end
      MWR:  begin o.mw = 1; o.iord = 1; end
      EX:   begin o.a = 1; o.op = 2'b10; end
      RWB:  begin o.rw = 1; o.rd = 1; end
      BR:   begin o.a = 1; o.op = 2'b01; o.pcs = 2'b01; end
      IEX:  begin o.a = 1; o.b = 2'b10; o.op = (op == ADDI) ? 2'b00 : 2'b11; end
      IWB:  o.rw = 1;
      JMP:  o.pcs = 2'b10;
      TRP:  o.exc = 1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic step(input string nm, input logic sel, input logic rst, input logic [5:0] op,
                      input logic z, input logic rdy, input logic [3:0] st,
                      input logic pcw, input logic irw, input logic done);
    frame_t f;
    rst_n = rst; OpCode = op; Zero = z; MemReady = rdy;
    f.nm = nm; f.sel = sel; f.st = st;
    f.o = tbl(st, op);
    f.o.pcw = pcw; f.o.irw = irw; f.o.done = done;
    sbq.push_back(f);
    @(posedge clk); #1;
  endtask

  task automatic s(input string nm, input logic [5:0] op, input logic z, input logic rdy,
                   input logic [3:0] st, input logic pcw, input logic irw, input logic done);
    step(nm, 1'b0, 1'b1, op, z, rdy, st, pcw, irw, done);
  endtask

  task automatic fd(input string nm, input logic [5:0] op, input int waits);
    for (int i = 0; i < waits; i++) s(nm, op, 0, 0, F, 0, 0, 0);
    s(nm, op, 0, 1, F, 1, 1, 0);
    s(nm, op, 0, 1, D, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      frame_t f;
      logic [3:0] ast;
      o_t ao;
      f   = sbq.pop_front();
      ast = f.sel ? st_b : st_a;
      ao  = f.sel ? ob : oa;
      total++;
      if (ast !== f.st || ao !== f.o) begin
        bad++;
        $display("FAIL %s: dut%s state=%0d out=%b, want state=%0d out=%b",
                 f.nm, f.sel ? "_b" : "_a", ast, ao, f.st, f.o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; OpCode = '0; Zero = 0; MemReady = 1;
    repeat (3) @(posedge clk);
    #1;
    step("rst_hold", 0, 0, RT, 0, 1, IDLE, 0, 0, 0);
    step("rst_rel",  0, 1, RT, 0, 1, IDLE, 0, 0, 0);

    fd("rtype", RT, 0);
    s("rtype", RT, 0, 1, EX, 0, 0, 0);
    s("rtype", RT, 0, 1, RWB, 0, 0, 1);

    fd("lw", LW, 0);
    s("lw", LW, 0, 1, MADR, 0, 0, 0);
    s("lw", LW, 0, 1, MRD, 0, 0, 0);
    s("lw", LW, 0, 1, MWB, 0, 0, 1);

    fd("sw", SW, 0);
    s("sw", SW, 0, 1, MADR, 0, 0, 0);
    s("sw", SW, 0, 1, MWR, 0, 0, 1);

    fd("beq_z1", BEQ, 0); s("beq_z1", BEQ, 1, 1, BR, 1, 0, 1);
    fd("beq_z0", BEQ, 0); s("beq_z0", BEQ, 0, 1, BR, 0, 0, 1);
    fd("bne_z1", BNE, 0); s("bne_z1", BNE, 1, 1, BR, 0, 0, 1);
    fd("bne_z0", BNE, 0); s("bne_z0", BNE, 0, 1, BR, 1, 0, 1);

    fd("addi", ADDI, 0);
    s("addi", ADDI, 0, 1, IEX, 0, 0, 0);
    s("addi", ADDI, 0, 1, IWB, 0, 0, 1);
    fd("ori", ORI, 0);
    s("ori", ORI, 0, 1, IEX, 0, 0, 0);
    s("ori", ORI, 0, 1, IWB, 0, 0, 1);

    fd("jump", J, 0);
    s("jump", J, 0, 1, JMP, 1, 0, 1);

    // 2 fetch waits + 3 MEMRD waits: 10 cycles total
    fd("lw_stall", LW, 2);
    s("lw_stall", LW, 0, 1, MADR, 0, 0, 0);
    for (int i = 0; i < 3; i++) s("lw_stall", LW, 0, 0, MRD, 0, 0, 0);
    s("lw_stall", LW, 0, 1, MRD, 0, 0, 0);
    s("lw_stall", LW, 0, 1, MWB, 0, 0, 1);

    fd("lw_rst", LW, 0);
    s("lw_rst", LW, 0, 1, MADR, 0, 0, 0);
    step("lw_rst", 0, 0, LW, 0, 1, MRD, 0, 0, 0);
    total++;
    if (dut_a.op_q !== 6'b000000) begin
      bad++;
      $display("FAIL lw_rst_opcode: latched=%b want=000000", dut_a.op_q);
    end
    step("lw_rst", 0, 1, LW, 0, 1, IDLE, 0, 0, 0);

    s("illegal", BAD, 0, 1, F, 1, 1, 0);
    step("illegal_nop", 1, 1, BAD, 0, 1, D, 0, 0, 1);
    step("illegal_nop", 1, 1, BAD, 0, 1, F, 1, 1, 0);
    s("illegal_trap", BAD, 0, 1, TRP, 0, 0, 0);
    s("illegal_trap", BAD, 0, 1, TRP, 0, 0, 0);
    step("illegal_trap", 0, 0, BAD, 0, 1, TRP, 0, 0, 0);
    step("trap_rst", 0, 1, J, 0, 1, IDLE, 0, 0, 0);

    fd("post_trap_j", J, 0);
    s("post_trap_j", J, 0, 1, JMP, 1, 0, 1);

    @(negedge clk); #1;
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: pending=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
